combination_serializer: RTL
===========================

COMBINATION_SERIALIZER -- requirements
Module: combination_serializer

Interface
REQ-001 Parameter LANE, default 4, number of parallel input lanes.
REQ-002 Parameter COMB_WIDTH, default 16, channel-bitset width.
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of two and at least LANE.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_channel_bitset  input  COMB_WIDTH x [LANE-1:0]  combination bitsets from the extractor.
REQ-007 in_valid  input  LANE  per-lane valid; sparse, any pattern allowed.
REQ-008 m_tdata  output  COMB_WIDTH  head combination.
REQ-009 m_tvalid  output  1  head valid.
REQ-010 m_tready  input  1  downstream accept.
REQ-011 fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky drop indicator.
REQ-013 debug_comb_ser  output  32 x [2:0]  statistics; present only with the macro.

Function
REQ-014 Stage 1 SHALL register the compacted valid lanes, lowest lane index first, together with n = popcount(in_valid).
REQ-015 Stage 2 SHALL write all n words atomically when n <= DEPTH - fill_level, where fill_level is sampled before this cycle's read.
REQ-016 When n exceeds free space, all n words SHALL be dropped, with no partial write, and overflow SHALL set.
REQ-017 Output order SHALL be cycle order, then ascending lane index within a cycle.
REQ-018 m_tvalid SHALL equal (fill_level != 0); m_tdata SHALL be the head entry.
REQ-019 A transfer SHALL occur when m_tvalid and m_tready are both high; the head pointer then advances by 1.
REQ-020 m_tdata SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-021 Latency: a word presented at edge N SHALL be visible on m_tvalid/m_tdata after edge N+2 when the FIFO was empty.
REQ-022 A simultaneous write and read SHALL update fill_level to fill_level + n - 1.
REQ-023 Pointers SHALL wrap modulo DEPTH; fill_level SHALL reach DEPTH exactly when full.
REQ-024 A cycle with n=0 SHALL cause no write and no state change besides reads.

Reset
REQ-025 Reset SHALL force m_tvalid=0, fill_level=0, overflow=0, both pointers to 0, the stage-1 count to 0, and all debug counters to 0.
REQ-026 m_tdata SHALL be don't-care during and after reset until the first write.
REQ-027 Reset mid-operation SHALL discard all buffered and in-flight words.

Configuration
REQ-028 With COMB_SERIALIZER_STATS_EN defined, debug_comb_ser[0] SHALL count accepted words, [1] dropped words, and [2] maximum fill_level observed.
REQ-029 The [0] and [1] counters SHALL saturate at 0xFFFFFFFF.
REQ-030 Without COMB_SERIALIZER_STATS_EN, the debug_comb_ser port and its counters SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package comb_pkg SHALL hold LANE_DEFAULT, COMB_WIDTH_DEFAULT, and the bitset typedef shared with the extractor.
REQ-032 The lane compactor SHALL be a sub-module, comb_lane_compactor, that is purely combinational and produces the packed words and n; the FIFO remains in the top module.

Verification (LANE=4, COMB_WIDTH=16, DEPTH=16)
REQ-033 in_valid=1011 with bitsets lane0=0x0001, lane1=0x0104, lane3=0x8000, m_tready=1 -> m_tdata 0x0001, 0x0104, 0x8000 on 3 consecutive transfers, the first after edge N+2.
REQ-034 m_tready=0 and in_valid=1111 for 5 cycles -> fill_level=16, overflow=1, the 5th cycle's 4 words dropped, debug [0]=16, [1]=4, [2]=16.
REQ-035 fill_level=15 then in_valid=0011 -> both words dropped, fill_level stays 15, and any read still proceeds.
REQ-036 m_tready toggling 1010... during 8 queued words -> m_tdata unchanged on every stall cycle; all 8 words delivered in order.
REQ-037 Reset asserted asynchronously at fill_level=10 -> m_tvalid=0, fill_level=0, and overflow=0 immediately; no stale word appears after release.
REQ-038 Build without COMB_SERIALIZER_STATS_EN -> elaborates without debug_comb_ser; REQ-033 through REQ-037 results are otherwise identical.

Source files
------------

// File: rtl/comb_pkg.sv
// Shared definitions for the combination extractor/serializer pair.
// Includes the saturating adder used by the optional COMB_SERIALIZER_STATS_EN counters.
package comb_pkg;

   localparam int LANE_DEFAULT       = 4;
   localparam int COMB_WIDTH_DEFAULT = 16;
   localparam int STAT_WIDTH         = 32;

   typedef logic [COMB_WIDTH_DEFAULT-1:0] comb_bitset_t;

   function automatic logic [STAT_WIDTH-1:0] sat_add32(
      input logic [STAT_WIDTH-1:0] a,
      input logic [STAT_WIDTH-1:0] b
   );
      logic [STAT_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[STAT_WIDTH] ? '1 : sum[STAT_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/comb_lane_compactor.sv
// Purely combinational lane compactor: packs valid lanes, lowest index first,
// into the low words of o_words and reports how many were packed.
module comb_lane_compactor #(
   parameter int LANE       = 4,
   parameter int COMB_WIDTH = 16,
   parameter int CNT_W      = $clog2(LANE + 1)
) (
   input  logic [LANE-1:0][COMB_WIDTH-1:0] i_bitset,
   input  logic [LANE-1:0]                 i_valid,
   output logic [LANE-1:0][COMB_WIDTH-1:0] o_words,
   output logic [CNT_W-1:0]                o_count
);

   localparam int IDX_W = (LANE > 1) ? $clog2(LANE) : 1;

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      o_words = '0;
      o_count = '0;
      for (int i = 0; i < LANE; i++) begin
         if (i_valid[i]) begin
            o_words[o_count[IDX_W-1:0]] = i_bitset[i];
            o_count                     = o_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/combination_serializer.sv
// Two-stage serializer: compact valid lanes, then write them atomically into a FIFO.
// Define COMB_SERIALIZER_STATS_EN to add the debug_comb_ser statistics port.
module combination_serializer
   import comb_pkg::*;
#(
   parameter int LANE       = LANE_DEFAULT,
   parameter int COMB_WIDTH = COMB_WIDTH_DEFAULT,
   parameter int DEPTH      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [LANE-1:0][COMB_WIDTH-1:0] in_channel_bitset,
   input  logic [LANE-1:0]                in_valid,
   output logic [COMB_WIDTH-1:0]          m_tdata,
   output logic                           m_tvalid,
   input  logic                           m_tready,
   output logic [$clog2(DEPTH):0]         fill_level,
   output logic                           overflow
`ifdef COMB_SERIALIZER_STATS_EN
   ,
   output logic [2:0][STAT_WIDTH-1:0]     debug_comb_ser
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam int CNT_W  = $clog2(LANE + 1);

   logic [LANE-1:0][COMB_WIDTH-1:0] w_words;
   logic [CNT_W-1:0]                w_count;

   logic [LANE-1:0][COMB_WIDTH-1:0] r_s1_words;
   logic [CNT_W-1:0]                r_s1_n;
   logic [COMB_WIDTH-1:0]           r_mem [DEPTH];
   logic [PTR_W-1:0]                r_wr_ptr;
   logic [PTR_W-1:0]                r_rd_ptr;
   logic [FILL_W-1:0]               r_fill;
   logic                            r_overflow;

   logic [FILL_W-1:0] w_n_ext;
   logic [FILL_W-1:0] w_free;
   logic              w_wr;
   logic              w_drop;
   logic              w_rd;
   logic [FILL_W-1:0] w_fill_next;

   comb_lane_compactor #(
      .LANE       (LANE),
      .COMB_WIDTH (COMB_WIDTH),
      .CNT_W      (CNT_W)
   ) u_compactor (
      .i_bitset (in_channel_bitset),
      .i_valid  (in_valid),
      .o_words  (w_words),
      .o_count  (w_count)
   );

   // Free space uses occupancy before this cycle's read, so a read never makes room for a write.
   assign w_n_ext     = FILL_W'(r_s1_n);
   assign w_free      = FILL_W'(DEPTH) - r_fill;
   assign w_wr        = (r_s1_n != '0) && (w_n_ext <= w_free);
   assign w_drop      = (r_s1_n != '0) && (w_n_ext > w_free);
   assign w_rd        = m_tvalid && m_tready;
   assign w_fill_next = r_fill + (w_wr ? w_n_ext : '0) - FILL_W'(w_rd);

   // NOTE: data-path storage carries no reset; only the count and pointers qualify it.
   always_ff @(posedge clk) begin
      r_s1_words <= w_words;
      if (w_wr) begin
         for (int k = 0; k < LANE; k++) begin
            if (CNT_W'(k) < r_s1_n) begin
               r_mem[r_wr_ptr + PTR_W'(k)] <= r_s1_words[k];
            end
         end
      end
   end

   // NOTE: non-blocking assignments keep all state updates concurrent at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_n     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_s1_n <= w_count;
         r_fill <= w_fill_next;
         if (w_wr)   r_wr_ptr   <= r_wr_ptr + PTR_W'(r_s1_n);
         if (w_rd)   r_rd_ptr   <= r_rd_ptr + 1'b1;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   assign m_tdata    = r_mem[r_rd_ptr];
   assign m_tvalid   = (r_fill != '0);
   assign fill_level = r_fill;
   assign overflow   = r_overflow;

`ifdef COMB_SERIALIZER_STATS_EN
   logic [STAT_WIDTH-1:0] r_stat_accepted;
   logic [STAT_WIDTH-1:0] r_stat_dropped;
   logic [STAT_WIDTH-1:0] r_stat_max_fill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_accepted <= '0;
         r_stat_dropped  <= '0;
         r_stat_max_fill <= '0;
      end else begin
         if (w_wr)   r_stat_accepted <= sat_add32(r_stat_accepted, STAT_WIDTH'(r_s1_n));
         if (w_drop) r_stat_dropped  <= sat_add32(r_stat_dropped, STAT_WIDTH'(r_s1_n));
         if (STAT_WIDTH'(w_fill_next) > r_stat_max_fill) begin
            r_stat_max_fill <= STAT_WIDTH'(w_fill_next);
         end
      end
   end

   assign debug_comb_ser[0] = r_stat_accepted;
   assign debug_comb_ser[1] = r_stat_dropped;
   assign debug_comb_ser[2] = r_stat_max_fill;
`endif

endmodule
